// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding controller: mux select codes,
// register index width and the shadow-pipeline entry.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } shadow_t;

  // A producer in a later stage matches a source only if it really writes a
  // non-zero register and the consumer actually reads that operand.
  function automatic logic shadow_hit(input shadow_t s,
                                      input logic [REG_ADDR_W-1:0] rs,
                                      input logic use_rs);
    return s.valid & s.regwrite & (s.rd != '0) & (s.rd == rs) & use_rs;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow-pipeline entry: async active-low reset, load enable, and a bubble
// input that loads an invalid entry instead of d.
module hazard_stage_reg
  import riscv_pipe_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    bubble,
  input  shadow_t d,
  output shadow_t q
);

  shadow_t entry_q;
  shadow_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (en) begin
      entry_d = bubble ? shadow_t'('0) : d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// HAZARD_FWD_EN defined: EX/MEM forwarding with load-use stall; undefined: no
// forwarding, stall on any RAW hit against EX or MEM until the producer is in WB.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_flush,
  input  logic                  stall_ext,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [CNT_W-1:0]      stall_cnt
);

  import riscv_pipe_pkg::*;

  shadow_t id_s;
  shadow_t ex_s;
  shadow_t mem_s;
  shadow_t wb_s;

  logic             pipe_en;
  logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic             raw_stall;
  logic             flush_eff;
  logic             flush_pend_q, flush_pend_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0]       sel_a_calc, sel_b_calc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign pipe_en = ~stall_ext;

  assign id_s = '{valid:    id_valid,
                  rd:       id_rd,
                  regwrite: id_regwrite,
                  memread:  id_memread};

  hazard_stage_reg u_ex_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .bubble (bubble_ex),
    .d      (id_s),
    .q      (ex_s)
  );

  hazard_stage_reg u_mem_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .bubble (1'b0),
    .d      (ex_s),
    .q      (mem_s)
  );

  hazard_stage_reg u_wb_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pipe_en),
    .bubble (1'b0),
    .d      (mem_s),
    .q      (wb_s)
  );

  assign ex_hit_a  = shadow_hit(ex_s,  id_rs1, id_use_rs1);
  assign ex_hit_b  = shadow_hit(ex_s,  id_rs2, id_use_rs2);
  assign mem_hit_a = shadow_hit(mem_s, id_rs1, id_use_rs1);
  assign mem_hit_b = shadow_hit(mem_s, id_rs2, id_use_rs2);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be covered by forwarding; it costs one bubble.
  assign raw_stall  = id_valid & ex_s.memread & (ex_hit_a | ex_hit_b);
  assign sel_a_calc = ex_hit_a ? FWD_MEM : (mem_hit_a ? FWD_WB : FWD_RF);
  assign sel_b_calc = ex_hit_b ? FWD_MEM : (mem_hit_b ? FWD_WB : FWD_RF);
`else
  assign raw_stall  = id_valid & (ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b);
  assign sel_a_calc = FWD_RF;
  assign sel_b_calc = FWD_RF;
`endif

  // A flush seen while frozen is remembered so it still lands on the first
  // unfrozen cycle, whether or not the branch unit keeps ex_flush asserted.
  assign flush_eff   = pipe_en & (ex_flush | flush_pend_q);
  assign flush_if_id = flush_eff;
  assign bubble_ex   = pipe_en & (flush_eff | raw_stall);
  assign stall_if_id = stall_ext | (raw_stall & ~flush_eff);

  always_comb begin
    flush_pend_d = flush_pend_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    stall_cnt_d  = stall_cnt_q;
    if (stall_ext) begin
      flush_pend_d = flush_pend_q | ex_flush;
    end else begin
      flush_pend_d = 1'b0;
      fwd_a_d      = bubble_ex ? FWD_RF : sel_a_calc;
      fwd_b_d      = bubble_ex ? FWD_RF : sel_b_calc;
      if (raw_stall && !flush_eff && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_q <= 1'b0;
      fwd_a_q      <= FWD_RF;
      fwd_b_q      <= FWD_RF;
      stall_cnt_q  <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

  // The WB entry is kept for observability; write-before-read means nothing
  // here consumes it, nor the memread bit beyond EX.
  logic unused_shadow;
  assign unused_shadow = ^{wb_s, mem_s.memread, ex_s.memread};

endmodule
